// File: rtl/pdm_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pdm_capture_ctrl
// Purpose  : PDM mic clock divider, settle discard, per-channel sample strobe
//            scheduling and start/busy/done framing for the capture path.
// Revision : 1.0 - initial release
// ============================================================================
module pdm_capture_ctrl #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                cfg_ratio,
    input  logic [7:0]                cfg_settle,
    input  logic [CNT_W-1:0]          cfg_frame_len,
    input  logic [NUM_CH-1:0]         cfg_ch_en,
    input  logic                      start,
    input  logic                      abort,
    output logic                      pdm_clk,
    output logic                      sample_stb,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);

    localparam int SEL_W = $clog2(NUM_CH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    logic [1:0]        state_q,   state_d;
    logic [7:0]        ratio_q,   ratio_d;
    logic [7:0]        settle_q,  settle_d;
    logic [CNT_W-1:0]  len_q,     len_d;
    logic [NUM_CH-1:0] en_q,      en_d;
    logic [7:0]        div_q,     div_d;
    logic [7:0]        scnt_q,    scnt_d;
    logic [CNT_W-1:0]  period_q,  period_d;
    logic [NUM_CH-1:0] rem_q,     rem_d;
    logic              pdm_q,     pdm_d;
    logic              stb_q,     stb_d;
    logic [SEL_W-1:0]  sel_q,     sel_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;

    logic              w_tick;
    logic              w_fall;
    logic              w_cfg_bad;
    logic [8:0]        w_scnt_nxt;
    logic [CNT_W:0]    w_period_nxt;
    logic [NUM_CH-1:0] w_src;
    logic [SEL_W-1:0]  w_lo_idx;

    assign w_tick       = (div_q == ratio_q - 8'd1);
    assign w_fall       = w_tick & pdm_q;
    assign w_cfg_bad    = (cfg_ratio < 8'd2) || (int'(cfg_ratio) < NUM_CH) ||
                          (cfg_frame_len == '0) || (cfg_ch_en == '0);
    assign w_scnt_nxt   = {1'b0, scnt_q} + {8'd0, w_fall};
    assign w_period_nxt = {1'b0, period_q} + {{CNT_W{1'b0}}, 1'b1};

    // A falling tick in CAPTURE seeds a new scan; otherwise keep draining the
    // channels still pending from the current one.
    assign w_src = (state_q == S_CAPTURE && w_fall) ? en_q : rem_q;

    always_comb begin
        w_lo_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_src[i]) w_lo_idx = SEL_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        ratio_d  = ratio_q;
        settle_d = settle_q;
        len_d    = len_q;
        en_d     = en_q;
        div_d    = div_q;
        scnt_d   = scnt_q;
        period_d = period_q;
        rem_d    = rem_q;
        pdm_d    = pdm_q;
        stb_d    = 1'b0;
        sel_d    = sel_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_SETTLE: begin
                div_d = w_tick ? 8'd0 : div_q + 8'd1;
                pdm_d = w_tick ? ~pdm_q : pdm_q;
                if (w_scnt_nxt >= {1'b0, settle_q}) begin
                    state_d = S_CAPTURE;
                    scnt_d  = 8'd0;
                end else begin
                    scnt_d  = w_scnt_nxt[7:0];
                end
            end
            S_CAPTURE: begin
                div_d = w_tick ? 8'd0 : div_q + 8'd1;
                pdm_d = w_tick ? ~pdm_q : pdm_q;
                if (w_src != '0) begin
                    stb_d = 1'b1;
                    sel_d = w_lo_idx;
                    rem_d = w_src & ~(NUM_CH'(1) << w_lo_idx);
                end else begin
                    rem_d = '0;
                end
                // Last strobe of a scan is on the outputs now: close the scan.
                if (stb_q && rem_q == '0) begin
                    if (w_period_nxt >= {1'b0, len_q}) begin
                        state_d  = S_IDLE;
                        done_d   = 1'b1;
                        pdm_d    = 1'b0;
                        div_d    = 8'd0;
                        period_d = '0;
                    end else begin
                        period_d = w_period_nxt[CNT_W-1:0];
                    end
                end
            end
            default: begin
                div_d = 8'd0;
                pdm_d = 1'b0;
                if (start) begin
                    if (w_cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = S_SETTLE;
                        ratio_d  = cfg_ratio;
                        settle_d = cfg_settle;
                        len_d    = cfg_frame_len;
                        en_d     = cfg_ch_en;
                        scnt_d   = 8'd0;
                        period_d = '0;
                        rem_d    = '0;
                    end
                end
            end
        endcase

        if (abort) begin
            state_d  = S_IDLE;
            div_d    = 8'd0;
            pdm_d    = 1'b0;
            scnt_d   = 8'd0;
            period_d = '0;
            rem_d    = '0;
            stb_d    = 1'b0;
            sel_d    = sel_q;
            done_d   = 1'b0;
            err_d    = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ratio_q  <= 8'd0;
            settle_q <= 8'd0;
            len_q    <= '0;
            en_q     <= '0;
            div_q    <= 8'd0;
            scnt_q   <= 8'd0;
            period_q <= '0;
            rem_q    <= '0;
            pdm_q    <= 1'b0;
            stb_q    <= 1'b0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ratio_q  <= ratio_d;
            settle_q <= settle_d;
            len_q    <= len_d;
            en_q     <= en_d;
            div_q    <= div_d;
            scnt_q   <= scnt_d;
            period_q <= period_d;
            rem_q    <= rem_d;
            pdm_q    <= pdm_d;
            stb_q    <= stb_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign pdm_clk    = pdm_q;
    assign sample_stb = stb_q;
    assign ch_sel     = sel_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = err_q;

endmodule
`default_nettype wire
